// File: rtl/requant_pkg.sv
// Shared constants and activation-mode encoding for the int32 -> int8 requantizer.
package requant_pkg;

  localparam int ACC_W_DFLT   = 32;
  localparam int MULT_W_DFLT  = 16;
  localparam int SHIFT_W_DFLT = 6;
  localparam int CNT_W_DFLT   = 16;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2
  } act_mode_e;

  // Encoding 3 is reserved and behaves as no activation.
  function automatic act_mode_e decode_act(input logic [1:0] m);
    case (m)
      2'd1:    return ACT_RELU;
      2'd2:    return ACT_RELU6;
      default: return ACT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sat_to_int8.sv
// Combinational clamp of a signed wide value to int8, with a flag set when clamping occurred.
module sat_to_int8
  import requant_pkg::*;
#(
  parameter int IN_W = 50
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [7:0]      dout,
  output logic                   sat
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(INT8_MAX);
  localparam logic signed [IN_W-1:0] LO = IN_W'(INT8_MIN);

  always_comb begin
    dout = din[7:0];
    sat  = 1'b0;
    if (din > HI) begin
      dout = 8'h7f;
      sat  = 1'b1;
    end else if (din < LO) begin
      dout = 8'h80;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/requant_int32_to_int8.sv
// Three-stage streaming requantizer: y = sat_int8(round_shift(acc*mult, shift) + zp), global stall.
// Optional fused ReLU/ReLU6 on the saturated result when REQUANT_FUSED_ACT_EN is defined.
module requant_int32_to_int8
  import requant_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DFLT,
  parameter int MULT_W  = MULT_W_DFLT,
  parameter int SHIFT_W = SHIFT_W_DFLT,
  parameter int CNT_W   = CNT_W_DFLT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [ACC_W-1:0]   in_acc,
  input  logic signed [MULT_W-1:0]  in_mult,
  input  logic        [SHIFT_W-1:0] in_shift,
  input  logic signed [7:0]         in_zp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [7:0]         out_y,
  output logic        [CNT_W-1:0]   sat_cnt,
  input  logic                      sat_clr
`ifdef REQUANT_FUSED_ACT_EN
  ,
  input  logic        [1:0]         act_mode
`endif
);

  localparam int PROD_W = ACC_W + MULT_W;
  localparam int T_W    = PROD_W + 2;
  localparam logic [SHIFT_W-1:0] SH_MAX = SHIFT_W'(PROD_W - 1);

  logic                      adv;
  logic                      s1_v, s2_v, out_sat;
  logic signed [PROD_W-1:0]  s1_prod;
  logic        [SHIFT_W-1:0] s1_shift;
  logic signed [7:0]         s1_zp, s2_zp;
  logic signed [PROD_W:0]    s2_r;

  logic        [SHIFT_W-1:0] sh_c;
  logic signed [PROD_W:0]    prod_x, rnd, biased, r_c;
  logic signed [T_W-1:0]     t_c;
  logic signed [7:0]         y_sat, y_c;
  logic                      sat_c;

`ifdef REQUANT_FUSED_ACT_EN
  act_mode_e s1_act, s2_act;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // One guard bit keeps prod + 2^(s-1) from overflowing; s=0 adds nothing.
  always_comb begin
    sh_c   = (s1_shift > SH_MAX) ? SH_MAX : s1_shift;
    prod_x = {s1_prod[PROD_W-1], s1_prod};
    rnd    = '0;
    if (sh_c != '0)
      rnd = {{PROD_W{1'b0}}, 1'b1} << (sh_c - SHIFT_W'(1));
    biased = prod_x + rnd;
    r_c    = biased >>> sh_c;
  end

  assign t_c = {s2_r[PROD_W], s2_r} + {{(T_W-8){s2_zp[7]}}, s2_zp};

  sat_to_int8 #(.IN_W(T_W)) u_sat (
    .din  (t_c),
    .dout (y_sat),
    .sat  (sat_c)
  );

`ifdef REQUANT_FUSED_ACT_EN
  always_comb begin
    y_c = y_sat;
    if (s2_act != ACT_NONE && y_sat[7])
      y_c = '0;
    if (s2_act == ACT_RELU6 && y_sat > 8'sd6)
      y_c = 8'sd6;
  end
`else
  assign y_c = y_sat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_sat   <= 1'b0;
      s1_prod   <= '0;
      s1_shift  <= '0;
      s1_zp     <= '0;
      s2_zp     <= '0;
      s2_r      <= '0;
`ifdef REQUANT_FUSED_ACT_EN
      s1_act    <= ACT_NONE;
      s2_act    <= ACT_NONE;
`endif
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_prod   <= PROD_W'(in_acc) * PROD_W'(in_mult);
      s1_shift  <= in_shift;
      s1_zp     <= in_zp;
      s2_v      <= s1_v;
      s2_r      <= r_c;
      s2_zp     <= s1_zp;
      out_valid <= s2_v;
      out_y     <= y_c;
      out_sat   <= sat_c;
`ifdef REQUANT_FUSED_ACT_EN
      s1_act    <= decode_act(act_mode);
      s2_act    <= s1_act;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || sat_clr)
      sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && sat_cnt != '1)
      sat_cnt <= sat_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_requant_int32_to_int8.sv
// Directed self-checking bench for requant_int32_to_int8 (act_mode cases when REQUANT_FUSED_ACT_EN is defined).
module tb_requant_int32_to_int8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, in_valid, in_ready, out_valid, out_ready, sat_clr;
  logic signed [31:0] in_acc;
  logic signed [15:0] in_mult;
  logic        [5:0]  in_shift;
  logic signed [7:0]  in_zp, out_y;
  logic        [15:0] sat_cnt;
`ifdef REQUANT_FUSED_ACT_EN
  logic        [1:0]  act_mode;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int rcv, sent, first, last, stale;
  int exp8 [8];

  requant_int32_to_int8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_mult   (in_mult),
    .in_shift  (in_shift),
    .in_zp     (in_zp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .sat_cnt   (sat_cnt),
`ifdef REQUANT_FUSED_ACT_EN
    .act_mode  (act_mode),
`endif
    .sat_clr   (sat_clr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int acc, input int mult, input int sh, input int zp);
    in_valid = v;
    in_acc   = acc;
    in_mult  = 16'(mult);
    in_shift = 6'(sh);
    in_zp    = 8'(zp);
  endtask

  // One beat into an empty pipe: checks acceptance, 3-cycle latency and the result.
  task automatic single(input string tag, input int acc, input int mult, input int sh,
                        input int zp, input int exp_y);
    @(negedge clk);
    drive(1'b1, acc, mult, sh, zp);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0);
    chk({tag, "_lat1"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_lat3"}, 32'(out_valid), 1);
    chk({tag, "_y"}, 32'(out_y), exp_y);
  endtask

  initial begin
    exp8 = '{-17, -12, -7, -2, 3, 8, 13, 18};
    rst_n = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
`ifdef REQUANT_FUSED_ACT_EN
    act_mode = 2'd0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_y", 32'(out_y), 0);
    chk("rst_sat_cnt", 32'(sat_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    single("sat_hi", 1000, 1, 0, 0, 127);
    @(negedge clk);
    chk("sat_cnt_1", 32'(sat_cnt), 1);
    single("round_zp", 300, 3, 4, -5, 51);
    single("round_neg", -24, 1, 4, 0, -1);
    @(negedge clk);
    chk("sat_cnt_still_1", 32'(sat_cnt), 1);
    single("sat_lo", -100000, 1000, 8, 0, -128);
    @(negedge clk);
    chk("sat_cnt_2", 32'(sat_cnt), 2);

    // Back-to-back: acc = 10*i-35, shift 1 -> (acc+1)>>>1
    rcv = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (rcv < 8) chk($sformatf("b2b_y%0d", rcv), 32'(out_y), exp8[rcv]);
        if (rcv == 0) first = c;
        last = c;
        rcv++;
      end
      if (c < 8) begin
        chk($sformatf("b2b_in_ready%0d", c), 32'(in_ready), 1);
        drive(1'b1, 10 * c - 35, 1, 1, 0);
      end else begin
        drive(1'b0, 0, 0, 0, 0);
      end
    end
    chk("b2b_count", rcv, 8);
    chk("b2b_span", last - first, 7);

    // Stall: beats y = 1..6, downstream blocked until pipe is full
    out_ready = 1'b0; sent = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(sent < 6, sent + 1, 1, 0, 0);
      if (in_ready && sent < 6) sent++;
    end
    chk("stall_sent", sent, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready%0d", c), 32'(in_ready), 0);
      chk($sformatf("stall_valid%0d", c), 32'(out_valid), 1);
      chk($sformatf("stall_y%0d", c), 32'(out_y), 1);
    end
    out_ready = 1'b1;
    #1;
    rcv = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        if (rcv < 6) chk($sformatf("drain_y%0d", rcv), 32'(out_y), rcv + 1);
        rcv++;
      end
      drive(sent < 6, sent + 1, 1, 0, 0);
      if (in_ready && sent < 6) sent++;
      @(negedge clk);
    end
    chk("drain_count", rcv, 6);
    chk("drain_sent", sent, 6);

    // Reset mid-stream with saturating beats in flight
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive(1'b1, 1000, 1, 0, 0);
    end
    chk("mid_valid_before", 32'(out_valid), 1);
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_sat_cnt", 32'(sat_cnt), 0);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("mid_no_stale", stale, 0);

    // Clear coinciding with a saturating handshake wins
    single("clr_pre", 1000, 1, 0, 0, 127);
    @(negedge clk);
    chk("clr_pre_cnt", 32'(sat_cnt), 1);
    single("clr_beat", 2000, 1, 0, 0, 127);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    chk("clr_cnt", 32'(sat_cnt), 0);

`ifdef REQUANT_FUSED_ACT_EN
    act_mode = 2'd2;
    single("act_relu6", 7, 1, 0, 0, 6);
    act_mode = 2'd1;
    single("act_relu", -3, 1, 0, 0, 0);
    act_mode = 2'd0;
    single("act_none", -3, 1, 0, 0, -3);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
